// File: rtl/board_input_conditioner_pkg.sv
// Shared board constants: default cycle counts for the supported pixel clocks
// and the logical button channel assignments.
package board_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_25M  = 250000;
  localparam int unsigned HOLD_CYCLES_25M      = 25200000;
  localparam int unsigned POR_CYCLES_25M       = 512;
  localparam int unsigned HEARTBEAT_CYCLES_25M = 25200000;

  localparam int unsigned DEBOUNCE_CYCLES_50M  = 500000;
  localparam int unsigned HOLD_CYCLES_50M      = 50400000;
  localparam int unsigned POR_CYCLES_50M       = 1024;
  localparam int unsigned HEARTBEAT_CYCLES_50M = 50400000;

  localparam int unsigned BTN_RESET  = 0;
  localparam int unsigned BTN_FIRE   = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 4;
  localparam int unsigned BTN_LEFT   = 5;
  localparam int unsigned BTN_RIGHT  = 6;

  // Width of a counter that must represent 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/board_input_conditioner_debounce.sv
// One button channel: 2-FF synchroniser, debounce counter, stable level with
// coincident press/release pulses, and a saturating long-hold counter.
module debounce_channel
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25M,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_25M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_norm,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic          meta;
  logic          sync;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          accept;

  assign accept = (sync != level) && (db_cnt == DB_LAST);
  assign held   = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta          <= 1'b0;
      sync          <= 1'b0;
      db_cnt        <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      meta          <= pin_norm;
      sync          <= meta;
      press_pulse   <= accept & sync;
      release_pulse <= accept & ~sync;
      if (accept)
        level <= sync;
      if ((sync == level) || accept)
        db_cnt <= '0;
      else
        db_cnt <= db_cnt + 1'b1;
      // Clearing on the accepting release edge drops held together with level.
      if (!level || (accept && !sync))
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/board_input_conditioner.sv
// Board input and reset conditioner: per-button debounce channels, power-up
// reset stretch, hold-to-reset, reset-button masking and heartbeat LED.
module board_input_conditioner
  import board_pkg::*;
#(
  parameter int unsigned           N_BTN            = 4,
  parameter logic [N_BTN-1:0]      BTN_ACTIVE_LOW   = N_BTN'(4'b0001),
  parameter int unsigned           DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_25M,
  parameter int unsigned           HOLD_CYCLES      = HOLD_CYCLES_25M,
  parameter int unsigned           POR_CYCLES       = POR_CYCLES_25M,
  parameter int unsigned           RESET_BTN        = BTN_RESET,
  parameter int unsigned           HEARTBEAT_CYCLES = HEARTBEAT_CYCLES_25M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_held,
  output logic             sys_rst_n,
  output logic             heartbeat
);

  localparam int unsigned PW  = cnt_width(POR_CYCLES);
  localparam int unsigned HBW = cnt_width(HEARTBEAT_CYCLES);
  localparam logic [PW-1:0]  POR_MAX = PW'(POR_CYCLES);
  localparam logic [HBW-1:0] HB_LAST = HBW'(HEARTBEAT_CYCLES - 1);

  logic [N_BTN-1:0] pin_norm;
  logic [N_BTN-1:0] level_int;
  logic [N_BTN-1:0] press_int;
  logic [N_BTN-1:0] release_int;
  logic [N_BTN-1:0] held_int;
  logic [N_BTN-1:0] mask;
  logic [PW-1:0]    por_cnt;
  logic [HBW-1:0]   hb_cnt;
  logic             por_done;

  assign pin_norm = btn_raw ^ BTN_ACTIVE_LOW;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pin_norm     (pin_norm[i]),
      .level        (level_int[i]),
      .press_pulse  (press_int[i]),
      .release_pulse(release_int[i]),
      .held         (held_int[i])
    );
  end

  assign por_done = (por_cnt == POR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      por_cnt   <= '0;
      sys_rst_n <= 1'b0;
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else begin
      if (!por_done)
        por_cnt <= por_cnt + 1'b1;
      sys_rst_n <= por_done & ~held_int[RESET_BTN];
      if (hb_cnt == HB_LAST) begin
        hb_cnt    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // The reset button is invisible to the core while it holds the core in reset.
  always_comb begin
    mask            = '0;
    mask[RESET_BTN] = ~sys_rst_n;
  end

  assign btn_level   = level_int & ~mask;
  assign btn_press   = press_int & ~mask;
  assign btn_release = release_int & ~mask;
  assign btn_held    = held_int;

endmodule
